// File: rtl/dma_pkg.sv
// Shared types, defaults and width helpers for the block-reader DMA.
package dma_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BLOCK_SIZE = 25;
  localparam int DEF_MEM_DEPTH  = 4096;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  // Length field must encode 0..BLOCK_SIZE inclusive.
  function automatic int len_w(input int block_size);
    return $clog2(block_size + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_sram.sv
// Single-port synchronous SRAM with registered read data; contents are not reset.
module dma_sram
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int AW         = idx_w(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dma_block_reader.sv
// Burst reader: fills a BLOCK_SIZE-slot output block from a local word memory.
// Optional macro DMA_STRIDE_EN adds cmd_stride for strided fetch (default stride 1).
module dma_block_reader
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  localparam int LEN_W     = len_w(BLOCK_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [LEN_W-1:0]                 cmd_len,
`ifdef DMA_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]            cmd_stride,
`endif
  output logic                             busy,
  output logic                             done,
  output logic                             block_valid,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] block_data
);

  localparam int MAW    = idx_w(MEM_DEPTH);
  localparam int SLOT_W = idx_w(BLOCK_SIZE);

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] stride;
  logic [ADDR_WIDTH-1:0] mem_addr_full;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued;
  logic [LEN_W-1:0]      eff_len;
  logic [SLOT_W-1:0]     rd_slot;
  logic                  rd_pending;
  logic                  cmd_accept;
  logic                  wr_we;
  logic                  last_issue;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] slots [BLOCK_SIZE];

  assign wr_ready   = (state == IDLE);
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign wr_we      = wr_valid && wr_ready;
  assign last_issue = (state == READ) && (issued == len_q - LEN_W'(1));
  assign eff_len    = (cmd_len == '0 || cmd_len > LEN_W'(BLOCK_SIZE)) ? LEN_W'(BLOCK_SIZE) : cmd_len;

  // Writes only happen in IDLE, so the single port is shared by address muxing.
  assign mem_addr_full = (state == IDLE) ? wr_addr : rd_addr;

  if (ADDR_WIDTH > MAW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr_full[ADDR_WIDTH-1:MAW];
  end

`ifndef DMA_STRIDE_EN
  assign stride = ADDR_WIDTH'(1);
`endif

  dma_sram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (MAW)
  ) u_sram (
    .clk  (clk),
    .we   (wr_we),
    .addr (mem_addr_full[MAW-1:0]),
    .wdata(wr_data),
    .rdata(rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_accept) state_next = READ;
      READ:    if (last_issue) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data lags the issued address by one edge; rd_pending/rd_slot track it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr     <= '0;
`ifdef DMA_STRIDE_EN
      stride      <= '0;
`endif
      len_q       <= '0;
      issued      <= '0;
      rd_slot     <= '0;
      rd_pending  <= 1'b0;
      done        <= 1'b0;
      block_valid <= 1'b0;
      for (int unsigned i = 0; i < BLOCK_SIZE; i++) slots[i] <= '0;
    end else begin
      done       <= (state == DRAIN);
      rd_pending <= (state == READ);
      rd_slot    <= issued[SLOT_W-1:0];
      if (cmd_accept) begin
        rd_addr     <= cmd_addr;
`ifdef DMA_STRIDE_EN
        stride      <= cmd_stride;
`endif
        len_q       <= eff_len;
        issued      <= '0;
        block_valid <= 1'b0;
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) slots[i] <= '0;
      end else if (state == READ) begin
        rd_addr <= rd_addr + stride;
        issued  <= issued + LEN_W'(1);
      end
      if (rd_pending) slots[rd_slot] <= rdata;
      if (state == DRAIN) block_valid <= 1'b1;
    end
  end

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_pack
    assign block_data[g*DATA_WIDTH +: DATA_WIDTH] = slots[g];
  end

endmodule

// File: tb/tb_dma_block_reader.sv
// Self-checking bench for dma_block_reader against a word-array reference model.
module tb_dma_block_reader;
  import dma_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BS = 25;
  localparam int MD = 4096;
  localparam int LW = len_w(BS);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [AW-1:0]  wr_addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [AW-1:0]  cmd_addr = '0;
  logic [LW-1:0]  cmd_len = '0;
`ifdef DMA_STRIDE_EN
  logic [AW-1:0]  cmd_stride = '0;
`endif
  logic           busy;
  logic           done;
  logic           block_valid;
  logic [BS*DW-1:0] block_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_mem [MD];

  always #5 clk = ~clk;

  dma_block_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BLOCK_SIZE(BS),
    .MEM_DEPTH (MD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
`ifdef DMA_STRIDE_EN
    .cmd_stride (cmd_stride),
`endif
    .busy       (busy),
    .done       (done),
    .block_valid(block_valid),
    .block_data (block_data)
  );

  task automatic check(input string tag, input logic [BS*DW-1:0] obs, input logic [BS*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input int len);
    return (len == 0 || len > BS) ? BS : len;
  endfunction

  function automatic logic [BS*DW-1:0] expected_block(input int base, input int len, input int stride);
    logic [BS*DW-1:0] b;
    b = '0;
    for (int k = 0; k < eff_len(len); k++)
      b[k*DW +: DW] = model_mem[(base + k * stride) % MD];
    return b;
  endfunction

  task automatic write_word(input int a, input logic [DW-1:0] d);
    int n;
    wr_addr  = AW'(a);
    wr_data  = d;
    wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 60) begin tick(); n++; end
    check("wr_ready", {399'b0, wr_ready}, 1);
    @(posedge clk);
    model_mem[a % MD] = d;
    #1;
    wr_valid = 1'b0;
  endtask

  // Drives a command and returns the model's expected block at the accept edge.
  task automatic start_burst(input int base, input int len, input int stride,
                             output logic [BS*DW-1:0] exp);
    int n;
    cmd_addr  = AW'(base);
    cmd_len   = LW'(len);
`ifdef DMA_STRIDE_EN
    cmd_stride = AW'(stride);
`endif
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 60) begin tick(); n++; end
    check("cmd_ready", {399'b0, cmd_ready}, 1);
    @(posedge clk);
    if (wr_valid && wr_ready) model_mem[int'(wr_addr) % MD] = wr_data;
    exp = expected_block(base, len, stride);
    #1;
    cmd_valid = 1'b0;
    check("busy_after_accept", {399'b0, busy}, 1);
    check("block_cleared", block_data, '0);
    check("bv_after_accept", {399'b0, block_valid}, 0);
  endtask

  task automatic finish_burst(input string tag, input int len, input logic [BS*DW-1:0] exp);
    int n;
    n = 1;
    while (!done && n < 60) begin
      if (wr_valid) check({tag, "_wr_held"}, {399'b0, wr_ready}, 0);
      tick();
      n++;
    end
    // n counts edges from the accept edge to the one that raised done.
    check({tag, "_latency"}, n, eff_len(len) + 1);
    check({tag, "_done"}, {399'b0, done}, 1);
    check({tag, "_bv"}, {399'b0, block_valid}, 1);
    check({tag, "_busy"}, {399'b0, busy}, 0);
    check({tag, "_data"}, block_data, exp);
  endtask

  task automatic burst(input string tag, input int base, input int len, input int stride);
    logic [BS*DW-1:0] exp;
    start_burst(base, len, stride, exp);
    tick();
    finish_burst(tag, len, exp);
    tick();
    check({tag, "_done_pulse"}, {399'b0, done}, 0);
    check({tag, "_bv_hold"}, {399'b0, block_valid}, 1);
  endtask

  initial begin
    logic [BS*DW-1:0] exp;
    int dones;
    int stride;

    #2;
    check("rst_busy", {399'b0, busy}, 0);
    check("rst_done", {399'b0, done}, 0);
    check("rst_bv", {399'b0, block_valid}, 0);
    check("rst_data", block_data, '0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 30; i++) write_word(i, DW'(16'h100 + i));
    for (int i = 30; i < 128; i++) write_word(i, DW'($urandom));

    burst("len0_full", 0, 0, 1);
    check("len0_slot24", {384'b0, block_data[24*DW +: DW]}, 16'h118);
    burst("len3", 2, 3, 1);
    check("len3_slot2", {384'b0, block_data[2*DW +: DW]}, 16'h104);
    check("len3_slot3", {384'b0, block_data[3*DW +: DW]}, 0);
    burst("len_over", 7, 31, 1);

    write_word(MD - 1, 16'hAAAA);
    write_word(0, 16'hBBBB);
    burst("wrap", MD - 1, 2, 1);
    check("wrap_slot1", {384'b0, block_data[DW +: DW]}, 16'hBBBB);

    // Write and command accepted together; a second write then waits out the burst.
    wr_addr = 5; wr_data = 16'h5555; wr_valid = 1'b1;
    start_burst(5, 1, 1, exp);
    wr_addr = 6; wr_data = 16'h6666;
    tick();
    finish_burst("same_cycle", 1, exp);
    check("same_cycle_slot0", {384'b0, block_data[DW-1:0]}, 16'h5555);
    check("held_wr_ready", {399'b0, wr_ready}, 1);
    @(posedge clk);
    model_mem[6] = 16'h6666;
    #1;
    wr_valid = 1'b0;
    burst("held_wr_commit", 5, 2, 1);

    start_burst(0, 25, 1, exp);
    tick(); tick(); tick();
    rst = 1'b1;
    #2;
    check("abort_busy", {399'b0, busy}, 0);
    check("abort_bv", {399'b0, block_valid}, 0);
    check("abort_data", block_data, '0);
    check("abort_done", {399'b0, done}, 0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    burst("after_abort", 3, 25, 1);

`ifdef DMA_STRIDE_EN
    burst("stride5", 0, 4, 5);
    burst("stride0", 0, 4, 0);
    check("stride0_slot3", {384'b0, block_data[3*DW +: DW]}, {384'b0, model_mem[0]});
`endif

    for (int r = 0; r < 20; r++) begin
      for (int w = 0; w < 3; w++) write_word($urandom_range(0, 127), DW'($urandom));
`ifdef DMA_STRIDE_EN
      stride = $urandom_range(0, 3);
`else
      stride = 1;
`endif
      burst("random", $urandom_range(0, 40), $urandom_range(0, 31), stride);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_block_reader.md
Name: dma_block_reader

Overview:
Parametrised successor to the CNN single-shot DMA. It holds a local word-addressed memory that is filled by single-word writes. On command, it reads a variable-length burst from any base address into a packed output block of BLOCK_SIZE words for the PE array. It adds valid/ready handshakes, a burst sequencer, completion signalling and address wrap.

Parameters:
ADDR_WIDTH, 16, word address width; MEM_DEPTH must be ≤ 2**ADDR_WIDTH
DATA_WIDTH, 16, word width
BLOCK_SIZE, 25, maximum words per burst and output block slot count
MEM_DEPTH, 4096, memory words; power of two

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready; equals (state==IDLE)
wr_addr  in  ADDR_WIDTH  write address, taken modulo MEM_DEPTH
wr_data  in  DATA_WIDTH  write data
cmd_valid  in  1  burst read request
cmd_ready  out  1  equals (state==IDLE)
cmd_addr  in  ADDR_WIDTH  burst base address
cmd_len  in  LEN_W=$clog2(BLOCK_SIZE+1)  word count; 0 or >BLOCK_SIZE means BLOCK_SIZE
busy  out  1  high from accept until done
done  out  1  one-cycle completion pulse
block_valid  out  1  block_data stable and complete
block_data  out  BLOCK_SIZE*DATA_WIDTH  slot i at [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset: state IDLE; busy=0, done=0, block_valid=0, block_data=0, counters=0. Memory contents are not reset. Reset mid-burst aborts the burst: no done pulse, block zeroed.
- States: IDLE -> READ on cmd accept. READ -> DRAIN after the last address is issued. DRAIN -> IDLE after the last word is captured, with done asserted for that cycle.
- Command accept (edge T0): latch base, effective length L and, where enabled, stride; clear all block slots to 0; block_valid<=0; busy<=1.
- READ: one address issued per edge, T1..TL. Address k = (base + k*stride) mod MEM_DEPTH, with stride=1 by default. Wrap past MEM_DEPTH-1 goes to 0.
- Memory read is synchronous, one cycle. Word k is captured into slot k at edge T(k+2).
- After edge T(L+1): done=1 and block_valid=1 for one cycle, then done=0. block_valid holds until the next accept. busy=0 from the same edge. Total latency from accept to done is L+1 cycles.
- Slots ≥ L remain 0.
- Writes are accepted only in IDLE and commit at the accepting edge.
- Simultaneous wr and cmd accept in the same IDLE cycle: both are taken. The burst observes the new data because the write commits before the first read at T1.
- Requests in READ/DRAIN: not accepted; the requester holds valid.
- Inputs other than handshakes are sampled only at accept.

Optional Feature:
DMA_STRIDE_EN.
- Defined: adds port cmd_stride (in, ADDR_WIDTH), latched at accept. Address k = (base + k*cmd_stride) mod MEM_DEPTH. Stride 0 replicates word base into all L slots. Used for column/strided feature-map fetch.
- Undefined: no port; stride fixed at 1.

Decomposition:
- Package dma_pkg: state enum {IDLE, READ, DRAIN}, LEN_W helper function, default parameter constants.
- Sub-module dma_sram: single-port synchronous memory, MEM_DEPTH × DATA_WIDTH, with write-enable, address, wdata and registered rdata. Single-port suffices because writes occur only in IDLE.
- Top level holds the FSM, address/slot counters and block register.

Test Plan:
- Write addr i data 0x100+i for i=0..29; cmd addr 0 len 0 -> done exactly 26 cycles after accept; slots 0..24 = 0x100..0x118; block_valid=1.
- cmd addr 2 len 3 -> slots 0..2 = 0x102,0x103,0x104; slots 3..24 = 0; done 4 cycles after accept.
- Write MEM_DEPTH-1 = 0xAAAA and 0 = 0xBBBB; cmd addr MEM_DEPTH-1 len 2 -> slot0=0xAAAA, slot1=0xBBBB.
- Same cycle: wr addr 5 data 0x5555 and cmd addr 5 len 1 -> slot0=0x5555. During the burst, wr_valid held with wr_ready=0; the write completes in the first IDLE cycle.
- Assert rst at cycle 3 of a len-25 burst -> busy=0, block_valid=0, block_data=0, no done. A new cmd afterwards behaves normally.
- DMA_STRIDE_EN: cmd addr 0 len 4 stride 5 -> slots = mem[0],mem[5],mem[10],mem[15]. Stride 0 -> all four slots = mem[0].
